// File: rtl/bcd_to_bin_if.sv
// Handshake bundle for the BCD-to-binary converter.
//   in_bcd/in_valid/in_ready : producer side, packed BCD operand (digit 0 in [3:0])
//   out_bin/out_err/out_valid/out_ready : consumer side, binary result plus bad-digit flag
// master = producer/consumer environment, slave = converter.
interface bcd_to_bin_if #(
  parameter int unsigned DIGITS = 2,
  parameter int unsigned BIN_W  = 7
);
  logic [4*DIGITS-1:0] in_bcd;
  logic                in_valid;
  logic                in_ready;
  logic [BIN_W-1:0]    out_bin;
  logic                out_err;
  logic                out_valid;
  logic                out_ready;

  modport master (
    output in_bcd, in_valid, out_ready,
    input  in_ready, out_bin, out_err, out_valid
  );

  modport slave (
    input  in_bcd, in_valid, out_ready,
    output in_ready, out_bin, out_err, out_valid
  );
endinterface

// File: rtl/bcd_to_bin.sv
// Sequential packed-BCD to unsigned binary converter (reverse double dabble:
// shift right one bit per cycle, then subtract 3 from every BCD digit >= 8).
// Ports:
//   clk    : rising-edge clock
//   resetn : asynchronous active-low reset
//   bus    : bcd_to_bin_if slave modport (in_bcd/in_valid/in_ready,
//            out_bin/out_err/out_valid/out_ready)
// One conversion in flight; in_ready only in IDLE, out_valid only in DONE.
// A bad digit (> 9) skips the shifting and reports out_err with out_bin = 0.
module bcd_to_bin #(
  parameter int unsigned DIGITS = 2,
  parameter int unsigned BIN_W  = 7
) (
  input  logic        clk,
  input  logic        resetn,
  bcd_to_bin_if.slave bus
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state,    stateNxt;
  logic [BCD_W-1:0] bcdReg,   bcdRegNxt;
  logic [BIN_W-1:0] binReg,   binRegNxt;
  logic [CNT_W-1:0] cnt,      cntNxt;
  logic [BIN_W-1:0] outBin,   outBinNxt;
  logic             outErr,   outErrNxt;
  logic             outValid, outValidNxt;
  logic             inReady,  inReadyNxt;

  logic             digitBad;
  logic [BCD_W-1:0] bcdShift;
  logic [BCD_W-1:0] bcdAdj;
  logic [BIN_W-1:0] binShift;
  logic [3:0]       dig;
  logic             lastStep;

  // State and datapath registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      bcdReg   <= '0;
      binReg   <= '0;
      cnt      <= '0;
      outBin   <= '0;
      outErr   <= 1'b0;
      outValid <= 1'b0;
      inReady  <= 1'b1;
    end else begin
      state    <= stateNxt;
      bcdReg   <= bcdRegNxt;
      binReg   <= binRegNxt;
      cnt      <= cntNxt;
      outBin   <= outBinNxt;
      outErr   <= outErrNxt;
      outValid <= outValidNxt;
      inReady  <= inReadyNxt;
    end
  end

  // One dabble step: shift the {bcd,bin} pair right, then correct each digit
  always_comb begin
    digitBad = 1'b0;
    bcdAdj   = '0;
    dig      = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bus.in_bcd[4*i +: 4] > 4'd9) digitBad = 1'b1;
    end
    bcdShift = bcdReg >> 1;
    binShift = {bcdReg[0], binReg[BIN_W-1:1]};
    for (int unsigned i = 0; i < DIGITS; i++) begin
      dig = bcdShift[4*i +: 4];
      bcdAdj[4*i +: 4] = (dig >= 4'd8) ? (dig - 4'd3) : dig;
    end
    lastStep = (cnt == CNT_W'(BIN_W - 1));
  end

  // Next-state and output decode
  always_comb begin
    stateNxt    = state;
    bcdRegNxt   = bcdReg;
    binRegNxt   = binReg;
    cntNxt      = cnt;
    outBinNxt   = outBin;
    outErrNxt   = outErr;
    outValidNxt = outValid;
    inReadyNxt  = inReady;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          inReadyNxt = 1'b0;
          if (digitBad) begin
            outBinNxt   = '0;
            outErrNxt   = 1'b1;
            outValidNxt = 1'b1;
            stateNxt    = DONE;
          end else begin
            bcdRegNxt = bus.in_bcd;
            binRegNxt = '0;
            cntNxt    = '0;
            stateNxt  = BUSY;
          end
        end
      end
      BUSY: begin
        bcdRegNxt = bcdAdj;
        binRegNxt = binShift;
        cntNxt    = cnt + CNT_W'(1);
        if (lastStep) begin
          outBinNxt   = binShift;
          outErrNxt   = 1'b0;
          outValidNxt = 1'b1;
          stateNxt    = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          outValidNxt = 1'b0;
          inReadyNxt  = 1'b1;
          stateNxt    = IDLE;
        end
      end
      default: begin
        outValidNxt = 1'b0;
        inReadyNxt  = 1'b1;
        stateNxt    = IDLE;
      end
    endcase
  end

  // Every BCD weight must have drained into the binary side by the last step
  always_ff @(posedge clk) begin
    if (resetn && state == BUSY && lastStep) begin
      assert (bcdAdj == '0);
    end
  end

  assign bus.in_ready  = inReady;
  assign bus.out_bin   = outBin;
  assign bus.out_err   = outErr;
  assign bus.out_valid = outValid;

endmodule

// File: tb/tb_bcd_to_bin.sv
// Directed bench for bcd_to_bin: a 2-digit instance (BIN_W=7) and a 3-digit
// instance (BIN_W=10) sharing clock and reset; expected values hand-computed.
module tb_bcd_to_bin;

  logic clk;
  logic resetn;
  int   passCnt;
  int   totalCnt;

  bcd_to_bin_if #(.DIGITS(2), .BIN_W(7))  b0 ();
  bcd_to_bin_if #(.DIGITS(3), .BIN_W(10)) b1 ();

  bcd_to_bin #(.DIGITS(2), .BIN_W(7))  dut2 (.clk(clk), .resetn(resetn), .bus(b0));
  bcd_to_bin #(.DIGITS(3), .BIN_W(10)) dut3 (.clk(clk), .resetn(resetn), .bus(b1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalCnt++;
    assert (obs === exp) passCnt++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic logic rdy(input int which);
    return (which == 0) ? b0.in_ready : b1.in_ready;
  endfunction

  function automatic logic ov(input int which);
    return (which == 0) ? b0.out_valid : b1.out_valid;
  endfunction

  function automatic logic oe(input int which);
    return (which == 0) ? b0.out_err : b1.out_err;
  endfunction

  function automatic logic [31:0] ob(input int which);
    return (which == 0) ? 32'(b0.out_bin) : 32'(b1.out_bin);
  endfunction

  task automatic drive(input int which, input logic [11:0] bcd, input logic v);
    if (which == 0) begin
      b0.in_bcd = bcd[7:0];
      b0.in_valid = v;
    end else begin
      b1.in_bcd = bcd;
      b1.in_valid = v;
    end
  endtask

  task automatic setOr(input int which, input logic r);
    if (which == 0) b0.out_ready = r;
    else b1.out_ready = r;
  endtask

  // Full transaction: accept, measure latency, optional backpressure, handshake
  task automatic doConv(input int which, input logic [11:0] bcd, input int expBin,
                        input logic expErr, input int expLat, input int holdCyc,
                        input string tag);
    int   n;
    logic rdyBad;
    logic holdBad;
    n = 0;
    while (!rdy(which) && n < 50) begin
      tick();
      n++;
    end
    chk({tag, " in_ready before"}, 32'(rdy(which)), 32'd1);
    drive(which, bcd, 1'b1);
    tick();
    drive(which, ~bcd, 1'b0);
    n = 0;
    rdyBad = 1'b0;
    while (!ov(which) && n < 40) begin
      if (rdy(which)) rdyBad = 1'b1;
      tick();
      n++;
    end
    if (rdy(which)) rdyBad = 1'b1;
    chk({tag, " latency"}, 32'(n), 32'(expLat));
    chk({tag, " in_ready low"}, 32'(rdyBad), 32'd0);
    chk({tag, " out_bin"}, ob(which), 32'(expBin));
    chk({tag, " out_err"}, 32'(oe(which)), 32'(expErr));
    holdBad = 1'b0;
    for (int h = 0; h < holdCyc; h++) begin
      tick();
      if (!ov(which) || ob(which) != 32'(expBin) || rdy(which)) holdBad = 1'b1;
    end
    if (holdCyc > 0) chk({tag, " hold stable"}, 32'(holdBad), 32'd0);
    setOr(which, 1'b1);
    tick();
    setOr(which, 1'b0);
    chk({tag, " out_valid drop"}, 32'(ov(which)), 32'd0);
    chk({tag, " in_ready back"}, 32'(rdy(which)), 32'd1);
    chk({tag, " out_bin kept"}, ob(which), 32'(expBin));
  endtask

  initial begin
    logic [11:0] v;
    passCnt  = 0;
    totalCnt = 0;
    resetn   = 1'b0;
    drive(0, 12'h000, 1'b0);
    drive(1, 12'h000, 1'b0);
    setOr(0, 1'b0);
    setOr(1, 1'b0);
    #12;
    chk("reset in_ready", 32'(b0.in_ready), 32'd1);
    chk("reset out_valid", 32'(b0.out_valid), 32'd0);
    chk("reset out_bin", 32'(b0.out_bin), 32'd0);
    chk("reset out_err", 32'(b0.out_err), 32'd0);
    resetn = 1'b1;
    tick();

    doConv(0, 12'h045, 45, 1'b0, 7, 0, "bcd45");
    doConv(0, 12'h03A, 0, 1'b1, 0, 0, "err3A");
    doConv(0, 12'h0F0, 0, 1'b1, 0, 0, "errF0");
    doConv(0, 12'h099, 99, 1'b0, 7, 0, "bcd99 after err");

    for (int t = 0; t < 10; t++) begin
      for (int o = 0; o < 10; o++) begin
        v = {4'h0, 4'(t), 4'(o)};
        doConv(0, v, 10 * t + o, 1'b0, 7, 0, "sweep");
      end
    end

    doConv(0, 12'h027, 27, 1'b0, 7, 5, "bp27");

    // Reset in the middle of a conversion of 64
    drive(0, 12'h064, 1'b1);
    tick();
    drive(0, 12'h000, 1'b0);
    tick();
    tick();
    tick();
    chk("mid busy in_ready", 32'(b0.in_ready), 32'd0);
    resetn = 1'b0;
    #2;
    chk("async rst in_ready", 32'(b0.in_ready), 32'd1);
    chk("async rst out_valid", 32'(b0.out_valid), 32'd0);
    chk("async rst out_bin", 32'(b0.out_bin), 32'd0);
    chk("async rst out_err", 32'(b0.out_err), 32'd0);
    resetn = 1'b1;
    tick();
    chk("post rst no output", 32'(b0.out_valid), 32'd0);
    doConv(0, 12'h012, 12, 1'b0, 7, 0, "bcd12 after rst");

    doConv(1, 12'h999, 999, 1'b0, 10, 0, "d3 999");
    doConv(1, 12'h500, 500, 1'b0, 10, 0, "d3 500");
    doConv(1, 12'hA00, 0, 1'b1, 0, 0, "d3 errA00");
    doConv(1, 12'h307, 307, 1'b0, 10, 2, "d3 307");

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
